// File: rtl/arb_seq_counter.sv
// arb_seq_counter: table-driven sequence counter.
// The count sequence is read from a runtime-programmable table indexed by idx_o.
// Features: enable, up/down direction, wrap or one-shot mode, synchronous load,
// a programmable last index, and a registered terminal-count pulse.
//
// Ports:
//   clk_i       rising-edge clock
//   reset_i     asynchronous active-high reset
//   en_i        advance one step this cycle
//   dir_i       1 = forward (idx+1), 0 = backward (idx-1)
//   mode_i      0 = wrap, 1 = one-shot (stop at terminal)
//   load_i      synchronous jump to load_idx_i (priority over en_i)
//   load_idx_i  load target index, clamped to the last index
//   cfg_we_i    table write strobe
//   cfg_addr_i  table write address
//   cfg_data_i  table write data
//   len_we_i    last-index write strobe
//   len_data_i  new last index (sequence length minus 1)
//   counts_o    registered table[idx]
//   idx_o       current index
//   tc_o        one-cycle terminal pulse
//   done_o      one-shot finished, sticky until load or reset
module arb_seq_counter #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned IDX_W = 4
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             en_i,
    input  logic             dir_i,
    input  logic             mode_i,
    input  logic             load_i,
    input  logic [IDX_W-1:0] load_idx_i,
    input  logic             cfg_we_i,
    input  logic [IDX_W-1:0] cfg_addr_i,
    input  logic [WIDTH-1:0] cfg_data_i,
    input  logic             len_we_i,
    input  logic [IDX_W-1:0] len_data_i,
    output logic [WIDTH-1:0] counts_o,
    output logic [IDX_W-1:0] idx_o,
    output logic             tc_o,
    output logic             done_o
);

    localparam int unsigned DEPTH = 2 ** IDX_W;

    logic [WIDTH-1:0] table_q [DEPTH];
    logic [IDX_W-1:0] last_q;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [WIDTH-1:0] counts_q, counts_d;
    logic             tc_q, tc_d;
    logic             done_q, done_d;

    logic step;
    logic at_term;

    assign step    = en_i & ~load_i & ~done_q;
    // idx may sit above last after a length write; forward treats that as terminal.
    assign at_term = dir_i ? (idx_q >= last_q) : (idx_q == '0);

    always_comb begin
        idx_d  = idx_q;
        done_d = done_q;
        tc_d   = 1'b0;

        if (load_i) begin
            idx_d  = (load_idx_i > last_q) ? last_q : load_idx_i;
            done_d = 1'b0;
        end else if (step) begin
            if (at_term && mode_i) begin
                // Blocked one-shot step: hold idx, flag completion once.
                done_d = 1'b1;
                tc_d   = 1'b1;
            end else if (at_term) begin
                // Wrap back to the start; not a terminal arrival.
                idx_d = dir_i ? '0 : last_q;
            end else begin
                idx_d = dir_i ? idx_q + IDX_W'(1) : idx_q - IDX_W'(1);
                tc_d  = dir_i ? (idx_d >= last_q) : (idx_d == '0);
            end
        end

        // Write-first bypass keeps counts consistent with the landing index.
        if (cfg_we_i && (cfg_addr_i == idx_d)) begin
            counts_d = cfg_data_i;
        end else begin
            counts_d = table_q[idx_d];
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                table_q[i] <= WIDTH'(i);
            end
            last_q   <= IDX_W'(DEPTH - 1);
            idx_q    <= '0;
            counts_q <= '0;
            tc_q     <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            if (cfg_we_i) begin
                table_q[cfg_addr_i] <= cfg_data_i;
            end
            if (len_we_i) begin
                last_q <= len_data_i;
            end
            idx_q    <= idx_d;
            counts_q <= counts_d;
            tc_q     <= tc_d;
            done_q   <= done_d;
        end
    end

    assign counts_o = counts_q;
    assign idx_o    = idx_q;
    assign tc_o     = tc_q;
    assign done_o   = done_q;

endmodule
